// File: rtl/tl_master_arbiter.sv
// rtl/tl_master_arbiter.sv - round-robin sharing of one TL-UL master port among NUM_REQ requesters
// A requests are tagged with the requester index as source; D responses route back by source.
module tl_master_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int SRC_SIZE  = 2,
    parameter int BUS_SIZE  = 8,
    parameter int ADR_WIDTH = 32
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_a_valid,
    output logic [NUM_REQ-1:0]              req_a_ready,
    input  logic [3*NUM_REQ-1:0]            req_a_opcode,
    input  logic [4*NUM_REQ-1:0]            req_a_size,
    input  logic [ADR_WIDTH*NUM_REQ-1:0]    req_a_address,
    input  logic [BUS_SIZE*NUM_REQ-1:0]     req_a_mask,
    input  logic [8*BUS_SIZE*NUM_REQ-1:0]   req_a_data,
    output logic [NUM_REQ-1:0]              req_d_valid,
    output logic [2:0]                      req_d_opcode,
    output logic                            req_d_denied,
    output logic [8*BUS_SIZE-1:0]           req_d_data,
    input  logic                            tl_a_ready,
    output logic                            tl_a_valid,
    output logic [2:0]                      tl_a_opcode,
    output logic [2:0]                      tl_a_param,
    output logic [3:0]                      tl_a_size,
    output logic [SRC_SIZE-1:0]             tl_a_source,
    output logic [ADR_WIDTH-1:0]            tl_a_address,
    output logic [BUS_SIZE-1:0]             tl_a_mask,
    output logic [8*BUS_SIZE-1:0]           tl_a_data,
    output logic                            tl_a_corrupt,
    input  logic                            tl_d_valid,
    output logic                            tl_d_ready,
    input  logic [2:0]                      tl_d_opcode,
    input  logic                            tl_d_denied,
    input  logic [SRC_SIZE-1:0]             tl_d_source,
    input  logic [8*BUS_SIZE-1:0]           tl_d_data,
    output logic                            busy,
    output logic                            err_spurious_d
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW   = 8 * BUS_SIZE;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

    state_e                 state_q, state_d;
    logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]     outstanding_q, outstanding_d;
    logic                   err_q, err_d;
    logic [2:0]             opcode_q, opcode_d;
    logic [3:0]             size_q, size_d;
    logic [SRC_SIZE-1:0]    source_q, source_d;
    logic [ADR_WIDTH-1:0]   address_q, address_d;
    logic [BUS_SIZE-1:0]    mask_q, mask_d;
    logic [DW-1:0]          data_q, data_d;

    logic [NUM_REQ-1:0]     eligible;
    logic                   grant_any;
    logic                   grant;
    logic [IDXW-1:0]        winner;
    logic [NUM_REQ-1:0]     d_hit;
    logic                   d_spurious;

    // Scan starts at rr_ptr and wraps, so the last winner has lowest priority.
    always_comb begin
        eligible  = req_a_valid & ~outstanding_q;
        grant_any = 1'b0;
        winner    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                winner    = IDXW'(idx);
            end
        end
        grant = (state_q == ST_IDLE) && grant_any;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a_ready[i] = grant && (winner == IDXW'(i));
        end
    end

    // A response only counts when its source names a requester that is waiting for one.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            d_hit[i] = tl_d_valid && (int'(tl_d_source) == i) && outstanding_q[i];
        end
        d_spurious = tl_d_valid && !(|d_hit);
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        outstanding_d = outstanding_q & ~d_hit;
        err_d         = err_q | d_spurious;
        opcode_d      = opcode_q;
        size_d        = size_q;
        source_d      = source_q;
        address_d     = address_q;
        mask_d        = mask_q;
        data_d        = data_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    outstanding_d[winner] = 1'b1;
                    opcode_d  = req_a_opcode[3*winner +: 3];
                    size_d    = req_a_size[4*winner +: 4];
                    address_d = req_a_address[ADR_WIDTH*winner +: ADR_WIDTH];
                    mask_d    = req_a_mask[BUS_SIZE*winner +: BUS_SIZE];
                    data_d    = req_a_data[DW*winner +: DW];
                    source_d  = SRC_SIZE'(winner);
                    rr_ptr_d  = (winner == IDXW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tl_a_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            opcode_q      <= '0;
            size_q        <= '0;
            source_q      <= '0;
            address_q     <= '0;
            mask_q        <= '0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            opcode_q      <= opcode_d;
            size_q        <= size_d;
            source_q      <= source_d;
            address_q     <= address_d;
            mask_q        <= mask_d;
            data_q        <= data_d;
        end
    end

    assign tl_a_valid     = (state_q == ST_SEND);
    assign tl_a_opcode    = opcode_q;
    assign tl_a_param     = 3'b000;
    assign tl_a_size      = size_q;
    assign tl_a_source    = source_q;
    assign tl_a_address   = address_q;
    assign tl_a_mask      = mask_q;
    assign tl_a_data      = data_q;
    assign tl_a_corrupt   = 1'b0;
    assign tl_d_ready     = 1'b1;
    assign req_d_valid    = d_hit;
    assign req_d_opcode   = tl_d_opcode;
    assign req_d_denied   = tl_d_denied;
    assign req_d_data     = tl_d_data;
    assign busy           = |outstanding_q;
    assign err_spurious_d = err_q;

endmodule
